// File: rtl/multicycle_control_unit.sv
// multicycle_control_unit
// Moore control FSM for the shared-datapath multicycle RISC-V core.
// Every instruction goes through FETCH, DECODE, then a short class-specific
// sequence of EXECUTE / MEMORY / WRITEBACK states. The unit drives all of
// the datapath enables and mux selects, and the ALU_Op code for the ALU
// control block. It also counts retired instructions and flags illegal
// opcodes.
//
// Optional feature macro: MULTICYCLE_BRANCH_EN
//   defined   : BRANCH (1100011) and JAL (1101111) are decoded and executed.
//   undefined : neither state is built. Both opcodes take the illegal path,
//               and PC_write_cond_o stays 0.
//
// Ports:
//   clk             rising-edge clock
//   reset           asynchronous, active-low reset
//   opcode_i        instruction[6:0] from the instruction register
//   zero_i          ALU zero flag (the datapath gates the conditional PC write)
//   mem_ready_i     memory read data valid this cycle
//   IR_write_o      load the instruction register
//   PC_write_o      unconditional PC update
//   PC_write_cond_o PC update when zero_i = 1
//   IorD_o          memory address: 0 = PC, 1 = ALU result register
//   mem_read_o      memory read strobe
//   mem_write_o     memory write strobe
//   ALU_src_a_o     00 = PC, 01 = rs1, 10 = old PC
//   ALU_src_b_o     00 = rs2, 01 = constant 4, 10 = immediate
//   ALU_Op_o        000 R, 001 I-arith, 010 ADD, 011 SUB, 100 LUI
//   reg_write_o     register file write enable
//   mem_to_reg_o    00 = ALU result reg, 01 = memory data reg, 10 = PC+4
//   PC_src_o        0 = ALU output, 1 = ALU result register
//   illegal_o       one-cycle pulse after an unknown opcode is decoded
//   retired_o       count of completed instructions (wraps)
module multicycle_control_unit #(
    parameter int CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [6:0]           opcode_i,
    input  logic                 zero_i,
    input  logic                 mem_ready_i,
    output logic                 IR_write_o,
    output logic                 PC_write_o,
    output logic                 PC_write_cond_o,
    output logic                 IorD_o,
    output logic                 mem_read_o,
    output logic                 mem_write_o,
    output logic [1:0]           ALU_src_a_o,
    output logic [1:0]           ALU_src_b_o,
    output logic [2:0]           ALU_Op_o,
    output logic                 reg_write_o,
    output logic [1:0]           mem_to_reg_o,
    output logic                 PC_src_o,
    output logic                 illegal_o,
    output logic [CNT_WIDTH-1:0] retired_o
);

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
`ifdef MULTICYCLE_BRANCH_EN
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
`endif

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        EXEC_R   = 4'd2,
        EXEC_I   = 4'd3,
        EXEC_LUI = 4'd4,
        WB_ALU   = 4'd5,
        MEM_ADDR = 4'd6,
        MEM_RD   = 4'd7,
        WB_MEM   = 4'd8,
`ifdef MULTICYCLE_BRANCH_EN
        BRANCH   = 4'd10,
        JAL      = 4'd11,
`endif
        MEM_WR   = 4'd9
    } state_t;

    state_t state, next_state;
    logic   retire;
    logic   illegal_next;

    // The branch outcome is applied in the datapath (PC_write_cond & zero),
    // so the control unit itself never needs the zero flag.
    logic unused_zero;
    assign unused_zero = zero_i;

    // State register, retired counter and registered illegal pulse.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= FETCH;
            retired_o <= '0;
            illegal_o <= 1'b0;
        end else begin
            state     <= next_state;
            illegal_o <= illegal_next;
            if (retire)
                retired_o <= retired_o + CNT_WIDTH'(1);
        end
    end

    // Next-state and Moore output decode. In FETCH, IR_write and PC_write
    // are also gated by mem_ready_i, so the IR only captures valid data.
    always_comb begin
        next_state      = state;
        retire          = 1'b0;
        illegal_next    = 1'b0;
        IR_write_o      = 1'b0;
        PC_write_o      = 1'b0;
        PC_write_cond_o = 1'b0;
        IorD_o          = 1'b0;
        mem_read_o      = 1'b0;
        mem_write_o     = 1'b0;
        ALU_src_a_o     = 2'b00;
        ALU_src_b_o     = 2'b00;
        ALU_Op_o        = 3'b000;
        reg_write_o     = 1'b0;
        mem_to_reg_o    = 2'b00;
        PC_src_o        = 1'b0;

        case (state)
            FETCH: begin
                mem_read_o  = 1'b1;
                ALU_src_b_o = 2'b01;
                ALU_Op_o    = 3'b010;
                IR_write_o  = mem_ready_i;
                PC_write_o  = mem_ready_i;
                if (mem_ready_i)
                    next_state = DECODE;
            end
            DECODE: begin
                ALU_src_a_o = 2'b10;
                ALU_src_b_o = 2'b10;
                ALU_Op_o    = 3'b010;
                case (opcode_i)
                    OP_R:      next_state = EXEC_R;
                    OP_I:      next_state = EXEC_I;
                    OP_LUI:    next_state = EXEC_LUI;
                    OP_LOAD,
                    OP_STORE:  next_state = MEM_ADDR;
`ifdef MULTICYCLE_BRANCH_EN
                    OP_BRANCH: next_state = BRANCH;
                    OP_JAL:    next_state = JAL;
`endif
                    default: begin
                        next_state   = FETCH;
                        illegal_next = 1'b1;
                    end
                endcase
            end
            EXEC_R: begin
                ALU_src_a_o = 2'b01;
                next_state  = WB_ALU;
            end
            EXEC_I: begin
                ALU_src_a_o = 2'b01;
                ALU_src_b_o = 2'b10;
                ALU_Op_o    = 3'b001;
                next_state  = WB_ALU;
            end
            EXEC_LUI: begin
                ALU_src_b_o = 2'b10;
                ALU_Op_o    = 3'b100;
                next_state  = WB_ALU;
            end
            WB_ALU: begin
                reg_write_o = 1'b1;
                retire      = 1'b1;
                next_state  = FETCH;
            end
            MEM_ADDR: begin
                ALU_src_a_o = 2'b01;
                ALU_src_b_o = 2'b10;
                ALU_Op_o    = 3'b010;
                // The IR still holds the instruction, so the opcode is
                // re-sampled here to pick the load or store path.
                if (opcode_i == OP_LOAD)
                    next_state = MEM_RD;
                else if (opcode_i == OP_STORE)
                    next_state = MEM_WR;
                else
                    next_state = FETCH;
            end
            MEM_RD: begin
                mem_read_o = 1'b1;
                IorD_o     = 1'b1;
                if (mem_ready_i)
                    next_state = WB_MEM;
            end
            WB_MEM: begin
                reg_write_o  = 1'b1;
                mem_to_reg_o = 2'b01;
                retire       = 1'b1;
                next_state   = FETCH;
            end
            MEM_WR: begin
                mem_write_o = 1'b1;
                IorD_o      = 1'b1;
                retire      = 1'b1;
                next_state  = FETCH;
            end
`ifdef MULTICYCLE_BRANCH_EN
            BRANCH: begin
                ALU_src_a_o     = 2'b01;
                ALU_Op_o        = 3'b011;
                PC_write_cond_o = 1'b1;
                PC_src_o        = 1'b1;
                retire          = 1'b1;
                next_state      = FETCH;
            end
            JAL: begin
                PC_write_o   = 1'b1;
                PC_src_o     = 1'b1;
                reg_write_o  = 1'b1;
                mem_to_reg_o = 2'b10;
                retire       = 1'b1;
                next_state   = FETCH;
            end
`endif
            default: next_state = FETCH;
        endcase
    end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Self-checking bench for multicycle_control_unit.
// The reference model keeps, for the instruction in flight, a queue of the
// steps that are still to run. The queue is built from the opcode class when
// DECODE is left. Memory steps repeat while mem_ready_i is low. Popping the
// last step of a legal instruction retires it. Expected control outputs come
// from a per-step table.
module tb_multicycle_control_unit;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    logic        clk;
    logic        reset;
    logic [6:0]  opcode_i;
    logic        zero_i;
    logic        mem_ready_i;
    logic        IR_write_o, PC_write_o, PC_write_cond_o, IorD_o;
    logic        mem_read_o, mem_write_o, reg_write_o, PC_src_o, illegal_o;
    logic [1:0]  ALU_src_a_o, ALU_src_b_o, mem_to_reg_o;
    logic [2:0]  ALU_Op_o;
    logic [31:0] retired_o;

    int checks   = 0;
    int failures = 0;
    bit checkEn  = 0;

    multicycle_control_unit #(.CNT_WIDTH(32)) dut (
        .clk(clk), .reset(reset), .opcode_i(opcode_i), .zero_i(zero_i),
        .mem_ready_i(mem_ready_i), .IR_write_o(IR_write_o),
        .PC_write_o(PC_write_o), .PC_write_cond_o(PC_write_cond_o),
        .IorD_o(IorD_o), .mem_read_o(mem_read_o), .mem_write_o(mem_write_o),
        .ALU_src_a_o(ALU_src_a_o), .ALU_src_b_o(ALU_src_b_o),
        .ALU_Op_o(ALU_Op_o), .reg_write_o(reg_write_o),
        .mem_to_reg_o(mem_to_reg_o), .PC_src_o(PC_src_o),
        .illegal_o(illegal_o), .retired_o(retired_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef enum {K_FETCH, K_DECODE, K_EXEC_R, K_EXEC_I, K_LUI, K_WB_ALU,
                  K_MEM_ADDR, K_MEM_RD, K_WB_MEM, K_MEM_WR, K_BRANCH, K_JAL} step_t;

    step_t       plan[$];
    step_t       modelCur;
    logic        mIllegal;
    logic [31:0] mRetired;

    // Reference model: advances on each active edge from the inputs that were applied.
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            plan     = {K_FETCH};
            mIllegal = 1'b0;
            mRetired = 32'd0;
        end else begin
            modelCur = plan[0];
            mIllegal = 1'b0;
            if (modelCur == K_FETCH) begin
                if (mem_ready_i) plan = {K_DECODE};
            end else if (modelCur == K_DECODE) begin
                case (opcode_i)
                    OP_R:      plan = {K_EXEC_R, K_WB_ALU};
                    OP_I:      plan = {K_EXEC_I, K_WB_ALU};
                    OP_LUI:    plan = {K_LUI, K_WB_ALU};
                    OP_LOAD:   plan = {K_MEM_ADDR, K_MEM_RD, K_WB_MEM};
                    OP_STORE:  plan = {K_MEM_ADDR, K_MEM_WR};
`ifdef MULTICYCLE_BRANCH_EN
                    OP_BRANCH: plan = {K_BRANCH};
                    OP_JAL:    plan = {K_JAL};
`endif
                    default: begin
                        plan     = {K_FETCH};
                        mIllegal = 1'b1;
                    end
                endcase
            end else if (!(modelCur == K_MEM_RD && !mem_ready_i)) begin
                void'(plan.pop_front());
                if (plan.size() == 0) begin
                    plan     = {K_FETCH};
                    mRetired = mRetired + 32'd1;
                end
            end
        end
    end

    // Expected control vector:
    // {IR_write, PC_write, PC_write_cond, IorD, mem_read, mem_write,
    //  src_a, src_b, ALU_Op, reg_write, mem_to_reg, PC_src}
    function automatic logic [16:0] expectedCtl(step_t s, logic rdy);
        logic ir = 0, pcw = 0, pcc = 0, iord = 0, mr = 0, mw = 0, rw = 0, pcs = 0;
        logic [1:0] sa = 0, sb = 0, m2r = 0;
        logic [2:0] op = 0;
        case (s)
            K_FETCH:    begin mr = 1; sb = 2'b01; op = 3'b010; ir = rdy; pcw = rdy; end
            K_DECODE:   begin sa = 2'b10; sb = 2'b10; op = 3'b010; end
            K_EXEC_R:   begin sa = 2'b01; end
            K_EXEC_I:   begin sa = 2'b01; sb = 2'b10; op = 3'b001; end
            K_LUI:      begin sb = 2'b10; op = 3'b100; end
            K_WB_ALU:   begin rw = 1; end
            K_MEM_ADDR: begin sa = 2'b01; sb = 2'b10; op = 3'b010; end
            K_MEM_RD:   begin mr = 1; iord = 1; end
            K_WB_MEM:   begin rw = 1; m2r = 2'b01; end
            K_MEM_WR:   begin mw = 1; iord = 1; end
            K_BRANCH:   begin sa = 2'b01; op = 3'b011; pcc = 1; pcs = 1; end
            K_JAL:      begin pcw = 1; pcs = 1; rw = 1; m2r = 2'b10; end
            default:    ;
        endcase
        return {ir, pcw, pcc, iord, mr, mw, sa, sb, op, rw, m2r, pcs};
    endfunction

    logic [16:0] dutCtl;
    assign dutCtl = {IR_write_o, PC_write_o, PC_write_cond_o, IorD_o, mem_read_o,
                     mem_write_o, ALU_src_a_o, ALU_src_b_o, ALU_Op_o, reg_write_o,
                     mem_to_reg_o, PC_src_o};

    task automatic checkOutput(input string name, input logic [31:0] act,
                               input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Compare process: checks every cycle on the falling edge.
    always @(negedge clk) begin
        if (checkEn) begin
            checkOutput("ctl", 32'(dutCtl), 32'(expectedCtl(plan[0], mem_ready_i)));
            checkOutput("illegal", 32'(illegal_o), 32'(mIllegal));
            checkOutput("retired", retired_o, mRetired);
        end
    end

    task automatic applyStimulus(input logic [6:0] opc, input logic rdy);
        opcode_i    = opc;
        mem_ready_i = rdy;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Runs one instruction from FETCH back to FETCH, with random memory waits.
    task automatic runInstr(input logic [6:0] opc, input int readyPct, output int cyc);
        bit left = 0;
        cyc = 0;
        do begin
            applyStimulus(opc, $urandom_range(0, 99) < readyPct);
            tick();
            cyc++;
            if (plan[0] != K_FETCH) left = 1;
        end while (!(left && plan[0] == K_FETCH) && cyc < 200);
        if (cyc >= 200) begin
            checks++;
            failures++;
            $display("[TB] FAIL instr_timeout opcode=%b cycles=%0d required<200", opc, cyc);
        end
    endtask

    int cyc;
    logic [6:0] opc;

    initial begin
        reset = 1'b1; opcode_i = 7'd0; mem_ready_i = 1'b0; zero_i = 1'b0;
        #1 reset = 1'b0;
        checkEn = 1;
        tick();
        checkOutput("reset_mem_read", 32'(mem_read_o), 1);
        checkOutput("reset_retired", retired_o, 0);
        checkOutput("reset_illegal", 32'(illegal_o), 0);
        #2 reset = 1'b1;
        tick();

        // R-type, no memory wait
        applyStimulus(OP_R, 1); tick();
        applyStimulus(OP_R, 1); tick();
        applyStimulus(OP_R, 1);
        checkOutput("exec_r_aluop", 32'(ALU_Op_o), 0);
        checkOutput("exec_r_src_a", 32'(ALU_src_a_o), 1);
        tick();
        applyStimulus(OP_R, 1);
        checkOutput("wb_alu_reg_write", 32'(reg_write_o), 1);
        tick();
        checkOutput("r_retired", retired_o, 1);

        // Load with three wait cycles in MEM_RD
        for (int i = 0; i < 3; i++) begin applyStimulus(OP_LOAD, 1); tick(); end
        for (int i = 0; i < 4; i++) begin
            applyStimulus(OP_LOAD, i == 3);
            checkOutput("mem_rd_strobe", 32'({mem_read_o, IorD_o}), 32'b11);
            tick();
        end
        applyStimulus(OP_LOAD, 1);
        checkOutput("wb_mem_sel", 32'(mem_to_reg_o), 1);
        checkOutput("load_not_yet_retired", retired_o, 1);
        tick();
        checkOutput("load_retired", retired_o, 2);

        // Store: mem_write for one cycle only
        for (int i = 0; i < 3; i++) begin applyStimulus(OP_STORE, 1); tick(); end
        checkOutput("mem_wr_strobe", 32'(mem_write_o), 1);
        checkOutput("mem_wr_no_reg_write", 32'(reg_write_o), 0);
        applyStimulus(OP_STORE, 0); tick();
        checkOutput("store_wr_dropped", 32'(mem_write_o), 0);
        checkOutput("store_retired", retired_o, 3);

        // Illegal opcode
        applyStimulus(7'b1111111, 1); tick();
        applyStimulus(7'b1111111, 0); tick();
        checkOutput("illegal_pulse", 32'(illegal_o), 1);
        checkOutput("illegal_back_in_fetch", 32'(mem_read_o), 1);
        checkOutput("illegal_no_retire", retired_o, 3);
        tick();
        checkOutput("illegal_one_cycle", 32'(illegal_o), 0);

        // Branch
        applyStimulus(OP_BRANCH, 1); tick();
        applyStimulus(OP_BRANCH, 0); tick();
`ifdef MULTICYCLE_BRANCH_EN
        checkOutput("branch_cond", 32'(PC_write_cond_o), 1);
        checkOutput("branch_aluop", 32'(ALU_Op_o), 3);
        tick();
        checkOutput("branch_retired", retired_o, 4);
`else
        checkOutput("branch_illegal", 32'(illegal_o), 1);
        checkOutput("branch_no_cond", 32'(PC_write_cond_o), 0);
        checkOutput("branch_no_retire", retired_o, 3);
`endif

        // Reset taken in the middle of MEM_RD
        for (int i = 0; i < 3; i++) begin applyStimulus(OP_LOAD, 1); tick(); end
        applyStimulus(OP_LOAD, 0);
        reset = 1'b0;
        #1;
        checkOutput("midreset_mem_read", 32'(mem_read_o), 1);
        checkOutput("midreset_iord", 32'(IorD_o), 0);
        checkOutput("midreset_retired", retired_o, 0);
        #1 reset = 1'b1;
        tick();
        runInstr(OP_R, 100, cyc);
        checkOutput("after_reset_latency", cyc, 4);
        checkOutput("after_reset_retired", retired_o, 1);

        runInstr(OP_LOAD, 100, cyc);
        checkOutput("load_latency", cyc, 5);
`ifdef MULTICYCLE_BRANCH_EN
        runInstr(OP_JAL, 100, cyc);
        checkOutput("jal_latency", cyc, 3);
`endif

        // Randomized instruction mix with random memory waits
        repeat (300) begin
            case ($urandom_range(0, 7))
                0: opc = OP_R;
                1: opc = OP_I;
                2: opc = OP_LUI;
                3: opc = OP_LOAD;
                4: opc = OP_STORE;
                5: opc = OP_BRANCH;
                6: opc = OP_JAL;
                default: opc = 7'($urandom);
            endcase
            runInstr(opc, 65, cyc);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/multicycle_control_unit.md
Name: multicycle_control_unit

Overview:
- Moore FSM that sequences the shared datapath of the multicycle RISC-V core. Sequencing covers the single ALU, PC, instruction register, register file and unified memory.
- Decodes the 7-bit opcode and steps each instruction through FETCH, DECODE, EXECUTE, MEMORY and WRITEBACK.
- Drives ALU_Op to the ALU control block and produces all datapath enables and mux selects.
- Counts retired instructions and flags illegal opcodes.

Parameters:
- CNT_WIDTH, 32, width of the retired-instruction counter.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- opcode_i  input  7  instruction[6:0] from the instruction register.
- zero_i  input  1  ALU zero flag.
- mem_ready_i  input  1  memory read data valid this cycle.
- IR_write_o  output  1  load the instruction register.
- PC_write_o  output  1  unconditional PC update.
- PC_write_cond_o  output  1  PC update when zero_i=1.
- IorD_o  output  1  memory address select: 0=PC, 1=ALU result register.
- mem_read_o  output  1  memory read strobe.
- mem_write_o  output  1  memory write strobe.
- ALU_src_a_o  output  2  00=PC, 01=rs1, 10=old PC.
- ALU_src_b_o  output  2  00=rs2, 01=constant 4, 10=immediate.
- ALU_Op_o  output  3  to ALU control.
- reg_write_o  output  1  register file write enable.
- mem_to_reg_o  output  2  writeback select: 00=ALU result register, 01=memory data register, 10=PC+4.
- PC_src_o  output  1  next-PC select: 0=ALU output, 1=ALU result register.
- illegal_o  output  1  one-cycle pulse on an unknown opcode.
- retired_o  output  CNT_WIDTH  count of completed instructions.

Behaviour:
- ALU_Op encoding:
  - 000: R-type.
  - 001: I-type arithmetic.
  - 010: forced ADD (PC+4, address calculation).
  - 011: forced SUB (branch compare).
  - 100: LUI pass-through.
- Outputs are registered-state decodes (Moore). Every strobe not listed for a state is 0; mux selects default to 00.
- Reset (reset=0):
  - state goes to FETCH immediately, retired_o=0, illegal_o=0.
  - Because outputs decode FETCH, mem_read_o=1 during reset.
  - Reset taken mid-instruction abandons the instruction without retiring it.
- FETCH:
  - mem_read_o=1, IorD_o=0, ALU_src_a_o=00, ALU_src_b_o=01, ALU_Op_o=010.
  - Hold while mem_ready_i=0.
  - On mem_ready_i=1: IR_write_o=1 and PC_write_o=1 (PC<=PC+4) in the same cycle, then go to DECODE.
  - IR_write_o and PC_write_o are qualified by mem_ready_i (Mealy exception).
- DECODE:
  - ALU_src_a_o=10, ALU_src_b_o=10, ALU_Op_o=010 (branch target precompute).
  - Next state by opcode:
    - 0110011 -> EXEC_R.
    - 0010011 -> EXEC_I.
    - 0110111 -> EXEC_LUI.
    - 0000011 or 0100011 -> MEM_ADDR.
    - 1100011 -> BRANCH.
    - 1101111 -> JAL.
    - Any other opcode -> FETCH with illegal_o=1 for that one cycle; nothing retires.
- EXEC_R: src_a=01, src_b=00, ALU_Op=000 -> WB_ALU.
- EXEC_I: src_a=01, src_b=10, ALU_Op=001 -> WB_ALU.
- EXEC_LUI: src_b=10, ALU_Op=100 -> WB_ALU.
- WB_ALU: reg_write_o=1, mem_to_reg_o=00 -> FETCH; retire.
- MEM_ADDR: src_a=01, src_b=10, ALU_Op=010.
  - Load -> MEM_RD; store -> MEM_WR.
  - The opcode is held by the IR and is re-sampled here.
- MEM_RD: mem_read_o=1, IorD_o=1.
  - Hold while mem_ready_i=0; on ready -> WB_MEM.
- WB_MEM: reg_write_o=1, mem_to_reg_o=01 -> FETCH; retire.
- MEM_WR: mem_write_o=1, IorD_o=1, asserted for exactly one cycle -> FETCH; retire.
- BRANCH: src_a=01, src_b=00, ALU_Op=011, PC_write_cond_o=1, PC_src_o=1 -> FETCH; retire.
- JAL: PC_write_o=1, PC_src_o=1, reg_write_o=1, mem_to_reg_o=10 -> FETCH; retire.
- Retire means retired_o increments by 1 on the clock edge that leaves the state. The counter wraps from all-ones to 0.
- Latency in cycles, with zero memory wait:
  - R, I, LUI: 4.
  - Load: 5.
  - Store: 4.
  - Branch: 3.
  - JAL: 3.
- Each memory wait cycle adds one cycle to the count.
- Unreachable state encodings go to FETCH on the next edge.

Optional Feature:
- Macro: MULTICYCLE_BRANCH_EN.
- Defined: opcodes 1100011 and 1101111 are decoded as described above.
- Undefined:
  - The BRANCH and JAL states are not built.
  - Both opcodes take the illegal path: illegal_o pulse, return to FETCH, no retire.
  - PC_write_cond_o is tied to 0.

Test Plan:
- Reset release, mem_ready_i=1, opcode 0110011:
  - FETCH, DECODE, EXEC_R with ALU_Op_o=000, WB_ALU with reg_write_o=1.
  - retired_o=1 after 4 cycles.
- Load 0000011 with mem_ready_i low for 3 cycles in MEM_RD:
  - mem_read_o=1 and IorD_o=1 held for 4 cycles.
  - WB_MEM with mem_to_reg_o=01; retired_o increments once.
- Store 0100011: mem_write_o high for exactly 1 cycle; total 4 cycles; no reg_write_o.
- Opcode 1111111 in DECODE: illegal_o pulses 1 cycle, next state FETCH, retired_o unchanged.
- Branch 1100011:
  - With macro: PC_write_cond_o=1 and ALU_Op_o=011 in cycle 3.
  - Without macro: illegal_o=1 and PC_write_cond_o stays 0.
- Reset asserted during MEM_RD:
  - Immediately mem_read_o=1, IorD_o=0, retired_o=0.
  - After release, the next instruction is fetched normally.
